dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data-memory/MMIO port between two requesters.
  - Port A: the CPU MEM stage.
  - Port B: the boot-loader/debug DMA engine.
- Performs round-robin arbitration with a bounded burst lock for port B.
- Registers read data and a per-port valid flag back to each requester.
- Sits between the pipeline MEM stage and the data memory. It produces the CPU stall request on contention.

Parameters:
- ADDR_W, 32, byte-address width on both requester ports and the memory port.
- DATA_W, 32, data width.
- MAX_BURST, 8, maximum consecutive port-B grants while b_lock is held when port A is waiting (range 1..255).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- a_req  input  1  CPU access request (MemRead or MemWrite asserted)
- a_we  input  1  CPU write enable (1 = write, 0 = read)
- a_addr  input  ADDR_W  CPU byte address
- a_wdata  input  DATA_W  CPU write data
- a_gnt  output  1  CPU request accepted this cycle (combinational)
- a_stall  output  1  a_req & ~a_gnt; freezes the pipeline
- a_rdata  output  DATA_W  registered read data for port A
- a_rvalid  output  1  a_rdata valid (one-cycle pulse)
- b_req  input  1  DMA access request
- b_we  input  1  DMA write enable
- b_lock  input  1  DMA asks to keep ownership for the next beat
- b_addr  input  ADDR_W  DMA byte address
- b_wdata  input  DATA_W  DMA write data
- b_gnt  output  1  DMA request accepted this cycle (combinational)
- b_rdata  output  DATA_W  registered read data for port B
- b_rvalid  output  1  b_rdata valid (one-cycle pulse)
- mem_addr  output  ADDR_W  address to data memory
- mem_wdata  output  DATA_W  write data to data memory
- mem_read  output  1  read strobe to data memory
- mem_write  output  1  write strobe to data memory
- mem_rdata  input  DATA_W  combinational read data from data memory

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - reset is synchronous, active-high and takes priority over all other logic.
  - Reset values: a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0; last_served = B (so A wins the first tie); burst_cnt = 0; locked = 0.
- Grant decision (combinational, at most one grant per cycle):
  - Only one requester active: that requester is granted.
  - Both active and locked = 1 and burst_cnt < MAX_BURST: grant B.
  - Both active otherwise: grant the port that is not last_served.
  - Neither active: no grant.
- Memory drive:
  - When granted, mem_addr, mem_wdata, mem_read (= ~we) and mem_write (= we) follow the granted port.
  - With no grant: mem_read = mem_write = 0, and mem_addr/mem_wdata are driven 0.
  - No write ever reaches memory without a grant. The memory must never see both strobes active in one cycle.
- Read return:
  - On a granted read, mem_rdata is captured at the clock edge into that port's rdata.
  - The port's rvalid is 1 for exactly the next cycle, giving 1-cycle latency.
  - A granted write produces no rvalid.
  - rdata holds its value until the next granted read on that port.
- State update on each grant:
  - last_served <= granted port.
  - Grant to B with b_lock = 1: locked <= 1, burst_cnt <= burst_cnt + 1, saturating at MAX_BURST.
  - Grant to B with b_lock = 0, or any grant to A: locked <= 0, burst_cnt <= 0.
  - A cycle with no grant: locked and burst_cnt are held.
- Starvation bound: with MAX_BURST = N, a continuously pending a_req is granted within N+1 cycles.
- A request that is not granted must be held stable by its requester until granted; the arbiter does not queue it.
- Reset mid-operation: a pending read's rvalid is suppressed, locked is cleared, and grants resume from the reset state on the cycle after reset deasserts.
- Contract checks (bench assertions): a_gnt & b_gnt never both 1; mem_read & mem_write never both 1.

Test Plan:
- Reset, then a_req=1, a_we=1, a_addr=0x10, a_wdata=0xDEADBEEF, no b_req -> a_gnt=1, a_stall=0, mem_write=1, mem_addr=0x10. A following A read of 0x10 -> a_rvalid=1 one cycle later with a_rdata=0xDEADBEEF.
- a_req and b_req both held with b_lock=0 -> grants alternate A, B, A, B, with A first after reset. a_stall=1 exactly in the B cycles.
- MAX_BURST=3, b_lock=1 and b_req held, a_req raised on the burst's second beat -> B is granted for 3 consecutive cycles, then A is granted on the next cycle.
- B writes 0x000000FF to 0x4000000C (LED register) while A is idle -> mem_write=1 with that address and data; no rvalid on either port.
- A read is granted, and reset is asserted on the following edge -> a_rvalid=0, burst_cnt=0. After release, a tie grants A first.
- Random req/we/lock traffic for 10k cycles -> gnt exclusivity holds, no ungranted strobe occurs, rdata matches a reference memory model, and A's maximum wait is ≤ MAX_BURST+1 cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter that shares the data-memory/MMIO port between the CPU MEM stage (A)
// and the boot/debug DMA engine (B). It uses round-robin arbitration with a bounded B burst lock.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_stall,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  port_e             r_last_served;
  logic              r_locked;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic [CNT_W-1:0]  w_cnt_next;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (a_req && b_req) begin
      // An active B lock wins ties only until the burst budget is spent.
      if (r_locked && (r_burst_cnt < MAX_CNT)) w_b_gnt = 1'b1;
      else if (r_last_served == PORT_B)        w_a_gnt = 1'b1;
      else                                     w_b_gnt = 1'b1;
    end else begin
      w_a_gnt = a_req;
      w_b_gnt = b_req;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (w_a_gnt) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_read  = ~a_we;
      mem_write = a_we;
    end else if (w_b_gnt) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_read  = ~b_we;
      mem_write = b_we;
    end
  end

  assign w_cnt_next = (r_burst_cnt == MAX_CNT) ? MAX_CNT : r_burst_cnt + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_served <= PORT_B;
      r_locked      <= 1'b0;
      r_burst_cnt   <= '0;
      r_a_rvalid    <= 1'b0;
      r_b_rvalid    <= 1'b0;
      r_a_rdata     <= '0;
      r_b_rdata     <= '0;
    end else begin
      r_a_rvalid <= w_a_gnt & ~a_we;
      r_b_rvalid <= w_b_gnt & ~b_we;
      if (w_a_gnt && !a_we) r_a_rdata <= mem_rdata;
      if (w_b_gnt && !b_we) r_b_rdata <= mem_rdata;

      if (w_a_gnt) begin
        r_last_served <= PORT_A;
        r_locked      <= 1'b0;
        r_burst_cnt   <= '0;
      end else if (w_b_gnt) begin
        r_last_served <= PORT_B;
        r_locked      <= b_lock;
        r_burst_cnt   <= b_lock ? w_cnt_next : '0;
      end
    end
  end

  assign a_gnt    = w_a_gnt;
  assign b_gnt    = w_b_gnt;
  assign a_stall  = a_req & ~w_a_gnt;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

endmodule
